// File: rtl/multi_rope_display.sv
// Multi-rope sprite for a VGA overlay.
// Each rope hangs from TOP_LEFT_Y and animates its length between
// MIN_LEN and MAX_LEN, one pixel every FRAMES_PER_STEP frames. The
// bottom ROPE_WIDTH rows of each rope are drawn as a knot. The pixel
// outputs are registered, so they lag pixelX/pixelY by one clock.
//
// Per-rope direction FSM:
//   state   | meaning
//   EXTEND  | length grows by one pixel per step until MAX_LEN
//   RETRACT | length shrinks by one pixel per step until MIN_LEN
module multi_rope_display #(
  parameter int          NUM_ROPES       = 4,
  parameter int          TOP_LEFT_X      = 150,
  parameter int          TOP_LEFT_Y      = 100,
  parameter int          ROPE_SPACING    = 64,
  parameter int          ROPE_WIDTH      = 4,
  parameter int          MIN_LEN         = 32,
  parameter int          MAX_LEN         = 160,
  parameter int          FRAMES_PER_STEP = 2,
  parameter logic [7:0]  ROPE_COLOR      = 8'h8C,
  parameter logic [7:0]  KNOT_COLOR      = 8'h64,
  parameter logic [7:0]  TRANSPARENT     = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        freeze,
  output logic        ropeDR,
  output logic [7:0]  ropeRGB,
  output logic [2:0]  ropeIndex
);

  typedef enum logic {
    EXTEND  = 1'b0,
    RETRACT = 1'b1
  } dir_t;

  localparam logic [9:0]  MIN_L      = 10'(MIN_LEN);
  localparam logic [9:0]  MAX_L      = 10'(MAX_LEN);
  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
  localparam logic [11:0] Y_TOP      = 12'(TOP_LEFT_Y);
  localparam logic [11:0] WIDTH_12   = 12'(ROPE_WIDTH);

  // Animation state
  logic       armed;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_nxt;
  logic       advance;
  logic       step;
  logic [9:0] len     [NUM_ROPES];
  logic [9:0] len_nxt [NUM_ROPES];
  dir_t       dir     [NUM_ROPES];
  dir_t       dir_nxt [NUM_ROPES];

  // Hit-test results
  logic [11:0] px;
  logic [11:0] py;
  logic        hit;
  logic        knot;
  logic [2:0]  hit_idx;

  assign px = {1'b0, pixelX};
  assign py = {1'b0, pixelY};

  // Armed goes high one clock after reset release, so a frame pulse
  // landing on the release edge is ignored rather than half-processed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Frame counter and per-rope length/direction registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= 8'd0;
      for (int i = 0; i < NUM_ROPES; i++) begin
        if ((i % 2) == 0) begin
          len[i] <= MIN_L;
          dir[i] <= EXTEND;
        end else begin
          len[i] <= MAX_L;
          dir[i] <= RETRACT;
        end
      end
    end else begin
      frame_cnt <= frame_cnt_nxt;
      for (int i = 0; i < NUM_ROPES; i++) begin
        len[i] <= len_nxt[i];
        dir[i] <= dir_nxt[i];
      end
    end
  end

  // Next-state: counter advance, step generation and length sweep.
  // Lengths only move on a frame pulse, so a frame is drawn with one
  // consistent set of lengths.
  always_comb begin
    advance       = startOfFrame && !freeze && armed;
    step          = advance && (frame_cnt == LAST_FRAME);
    frame_cnt_nxt = frame_cnt;
    if (advance) begin
      frame_cnt_nxt = step ? 8'd0 : frame_cnt + 8'd1;
    end
    for (int i = 0; i < NUM_ROPES; i++) begin
      len_nxt[i] = len[i];
      dir_nxt[i] = dir[i];
      if (step) begin
        case (dir[i])
          EXTEND: begin
            // >= rather than == so a length can never pass MAX_LEN
            if (len[i] + 10'd1 >= MAX_L) begin
              len_nxt[i] = MAX_L;
              dir_nxt[i] = RETRACT;
            end else begin
              len_nxt[i] = len[i] + 10'd1;
            end
          end
          RETRACT: begin
            if (len[i] <= MIN_L + 10'd1) begin
              len_nxt[i] = MIN_L;
              dir_nxt[i] = EXTEND;
            end else begin
              len_nxt[i] = len[i] - 10'd1;
            end
          end
          default: begin
            len_nxt[i] = MIN_L;
            dir_nxt[i] = EXTEND;
          end
        endcase
      end
    end
  end

  // Hit test against the current (pre-update) lengths. Scanning from
  // the highest index down lets the lowest-index hit win.
  always_comb begin
    logic [11:0] x_left;
    logic [11:0] y_bot;
    x_left  = 12'd0;
    y_bot   = 12'd0;
    hit     = 1'b0;
    knot    = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_ROPES - 1; i >= 0; i--) begin
      x_left = 12'(TOP_LEFT_X + i * ROPE_SPACING);
      y_bot  = Y_TOP + {2'b00, len[i]};
      if ((px >= x_left) && (px < x_left + WIDTH_12) &&
          (py >= Y_TOP) && (py < y_bot)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
        knot    = (py >= y_bot - WIDTH_12);
      end
    end
  end

  // Registered pixel outputs, one clock behind the pixel coordinates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ropeDR    <= 1'b0;
      ropeRGB   <= TRANSPARENT;
      ropeIndex <= 3'd0;
    end else begin
      ropeDR    <= hit;
      ropeRGB   <= hit ? (knot ? KNOT_COLOR : ROPE_COLOR) : TRANSPARENT;
      ropeIndex <= hit ? hit_idx : 3'd0;
    end
  end

endmodule

// File: tb/tb_multi_rope_display.sv
// Directed bench for multi_rope_display: reset state, pixel hit test,
// length sweep, freeze, overlap priority and mid-sweep reset.
module tb_multi_rope_display;

  logic        clk;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        freeze;
  logic        dr;
  logic [7:0]  rgb;
  logic [2:0]  idx;
  logic        dr2;
  logic [7:0]  rgb2;
  logic [2:0]  idx2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_rope_display dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .freeze(freeze),
    .ropeDR(dr), .ropeRGB(rgb), .ropeIndex(idx)
  );

  multi_rope_display #(.ROPE_SPACING(2), .ROPE_WIDTH(4)) dut_ovl (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .freeze(freeze),
    .ropeDR(dr2), .ropeRGB(rgb2), .ropeIndex(idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a pixel on a falling edge; outputs are valid at the next one.
  task automatic probe(input int x, input int y);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(negedge clk);
  endtask

  task automatic pulse_sof(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0; startOfFrame = 1'b0; freeze = 1'b0;
    pixelX = 11'd150; pixelY = 11'd100;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b1 == 1'b0, 8'hFF, 3'd0})
      $display("FAIL reset_outputs got dr=%b rgb=%h idx=%0d want 0/ff/0", dr, rgb, idx);
    else pass_cnt++;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pixels;
    probe(150, 132);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b0, 8'hFF, 3'd0})
      $display("FAIL miss_150_132 got dr=%b rgb=%h idx=%0d want 0/ff/0", dr, rgb, idx);
    else pass_cnt++;
    // latency: new hit pixel must not show before the next clock edge
    pixelX = 11'd150; pixelY = 11'd100;
    #1;
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL latency_early got dr=%b want 0", dr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b1, 8'h8C, 3'd0})
      $display("FAIL hit_150_100 got dr=%b rgb=%h idx=%0d want 1/8c/0", dr, rgb, idx);
    else pass_cnt++;
    probe(150, 131);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b1, 8'h64, 3'd0})
      $display("FAIL knot_150_131 got dr=%b rgb=%h idx=%0d want 1/64/0", dr, rgb, idx);
    else pass_cnt++;
    probe(214, 256);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b1, 8'h64, 3'd1})
      $display("FAIL knot_214_256 got dr=%b rgb=%h idx=%0d want 1/64/1", dr, rgb, idx);
    else pass_cnt++;
    probe(214, 255);
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b1, 8'h8C, 3'd1})
      $display("FAIL body_214_255 got dr=%b rgb=%h idx=%0d want 1/8c/1", dr, rgb, idx);
    else pass_cnt++;
    probe(153, 100);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL right_edge_in got dr=%b want 1", dr);
    else pass_cnt++;
    probe(154, 100);
    total_cnt++;
    if ({dr, rgb} !== {1'b0, 8'hFF})
      $display("FAIL right_edge_out got dr=%b rgb=%h want 0/ff", dr, rgb);
    else pass_cnt++;
    probe(149, 100);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL left_edge_out got dr=%b want 0", dr);
    else pass_cnt++;
    probe(150, 99);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL above_top got dr=%b want 0", dr);
    else pass_cnt++;
  endtask

  task automatic test_priority;
    probe(152, 100);
    total_cnt++;
    if ({dr2, rgb2, idx2} !== {1'b1, 8'h8C, 3'd0})
      $display("FAIL overlap_152 got dr=%b rgb=%h idx=%0d want 1/8c/0", dr2, rgb2, idx2);
    else pass_cnt++;
    probe(154, 100);
    total_cnt++;
    if ({dr2, idx2} !== {1'b1, 3'd1})
      $display("FAIL overlap_154 got dr=%b idx=%0d want 1/1", dr2, idx2);
    else pass_cnt++;
  endtask

  task automatic test_step;
    pulse_sof(2);
    probe(150, 132);
    total_cnt++;
    if ({dr, rgb} !== {1'b1, 8'h64})
      $display("FAIL len0_33_in got dr=%b rgb=%h want 1/64", dr, rgb);
    else pass_cnt++;
    probe(150, 133);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL len0_33_out got dr=%b want 0", dr);
    else pass_cnt++;
    probe(214, 259);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL len1_159_out got dr=%b want 0", dr);
    else pass_cnt++;
    probe(214, 258);
    total_cnt++;
    if ({dr, idx} !== {1'b1, 3'd1})
      $display("FAIL len1_159_in got dr=%b idx=%0d want 1/1", dr, idx);
    else pass_cnt++;
    pulse_sof(254);
    probe(150, 259);
    total_cnt++;
    if ({dr, rgb} !== {1'b1, 8'h64})
      $display("FAIL len0_160 got dr=%b rgb=%h want 1/64", dr, rgb);
    else pass_cnt++;
    probe(150, 260);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL len0_max_clamp got dr=%b want 0", dr);
    else pass_cnt++;
    probe(214, 132);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL len1_32_out got dr=%b want 0", dr);
    else pass_cnt++;
    pulse_sof(2);
    probe(150, 259);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL len0_retract_out got dr=%b want 0", dr);
    else pass_cnt++;
    probe(150, 258);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL len0_retract_in got dr=%b want 1", dr);
    else pass_cnt++;
    probe(214, 132);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL len1_extend_in got dr=%b want 1", dr);
    else pass_cnt++;
  endtask

  task automatic test_freeze;
    pulse_sof(1);
    freeze = 1'b1;
    pulse_sof(10);
    probe(150, 258);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL frozen_len0 got dr=%b want 1", dr);
    else pass_cnt++;
    probe(214, 133);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL frozen_len1 got dr=%b want 0", dr);
    else pass_cnt++;
    freeze = 1'b0;
    pulse_sof(1);
    probe(150, 258);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL resume_len0_out got dr=%b want 0", dr);
    else pass_cnt++;
    probe(150, 257);
    total_cnt++;
    if ({dr, rgb} !== {1'b1, 8'h64})
      $display("FAIL resume_len0_in got dr=%b rgb=%h want 1/64", dr, rgb);
    else pass_cnt++;
    probe(214, 133);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL resume_len1 got dr=%b want 1", dr);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    pulse_sof(116);
    probe(150, 189);
    total_cnt++;
    if ({dr, rgb} !== {1'b1, 8'h64})
      $display("FAIL len0_90_in got dr=%b rgb=%h want 1/64", dr, rgb);
    else pass_cnt++;
    probe(150, 150);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL pre_abort_hit got dr=%b want 1", dr);
    else pass_cnt++;
    #2;
    resetN = 1'b0;
    #1;
    total_cnt++;
    if ({dr, rgb, idx} !== {1'b0, 8'hFF, 3'd0})
      $display("FAIL async_clear got dr=%b rgb=%h idx=%0d want 0/ff/0", dr, rgb, idx);
    else pass_cnt++;
    // release together with a frame pulse: that pulse must be ignored
    @(negedge clk);
    resetN = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    pulse_sof(1);
    probe(150, 131);
    total_cnt++;
    if ({dr, rgb} !== {1'b1, 8'h64})
      $display("FAIL abort_len0_32_in got dr=%b rgb=%h want 1/64", dr, rgb);
    else pass_cnt++;
    probe(150, 132);
    total_cnt++;
    if (dr !== 1'b0)
      $display("FAIL abort_len0_32_out got dr=%b want 0", dr);
    else pass_cnt++;
    pulse_sof(1);
    probe(150, 132);
    total_cnt++;
    if (dr !== 1'b1)
      $display("FAIL abort_extend got dr=%b want 1", dr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_priority();
    test_step();
    test_freeze();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
